// File: rtl/spi_2_cmd_arbiter.sv
// spi_2_cmd_arbiter: round-robin scheduler sharing one SPI master command port among NREQ requesters,
// routing each result back to the requester that issued the previously accepted command.
module spi_2_cmd_arbiter #(
  parameter int NREQ = 4,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int S_ADDR_WIDTH = 2,
  parameter int CWIDTH = S_ADDR_WIDTH + 3 + AWIDTH + DWIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*CWIDTH-1:0] req_cmd,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]      rsp_data,
  input  logic [1:0]             cfg_in,
  output logic                   master_en,
  output logic [CWIDTH-1:0]      driver_data,
  output logic [1:0]             driver_cfg,
  input  logic                   driver_read,
  input  logic [DWIDTH-1:0]      spi_slv_read_data,
  output logic                   proto_err
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, ARB, DRAIN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, cur, cur_nx, oid, oid_nx, g, j;
  logic ov, ov_nx, hit, men_nx, perr_nx;
  logic [CWIDTH-1:0] dd_nx;
  logic [1:0] cfg_nx;
  logic [NREQ-1:0] ack_nx, rv_nx;
  logic [DWIDTH-1:0] rd_nx;
  always_comb begin
    g = ptr;
    hit = 1'b0;
    j = ptr;
    for (int k = 0; k < NREQ; k++) begin
      j = (j == IW'(NREQ - 1)) ? '0 : j + 1'b1;
      if (!hit && req[j]) begin
        g = j;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    cur_nx = cur;
    ov_nx = ov;
    oid_nx = oid;
    men_nx = master_en;
    dd_nx = driver_data;
    cfg_nx = driver_cfg;
    ack_nx = '0;
    rv_nx = '0;
    rd_nx = rsp_data;
    perr_nx = proto_err;
    case (state)
      IDLE: begin
        cfg_nx = cfg_in;
        perr_nx = proto_err | driver_read;
        if (hit) begin
          cur_nx = g;
          dd_nx = req_cmd[g*CWIDTH +: CWIDTH];
          men_nx = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: if (driver_read) begin
        ack_nx[cur] = 1'b1;
        if (ov) begin
          rv_nx[oid] = 1'b1;
          rd_nx = spi_slv_read_data;
        end
        ov_nx = 1'b1;
        oid_nx = cur;
        ptr_nx = cur;
        state_nx = ARB;
      end
      ARB: begin
        perr_nx = proto_err | driver_read;
        if (hit) begin
          cur_nx = g;
          dd_nx = req_cmd[g*CWIDTH +: CWIDTH];
        end
        state_nx = hit ? ISSUE : DRAIN;
      end
      DRAIN: begin
        // the closing pulse wins over a rejoining request in the same cycle
        if (driver_read) begin
          if (ov) begin
            rv_nx[oid] = 1'b1;
            rd_nx = spi_slv_read_data;
          end
          ov_nx = 1'b0;
          men_nx = 1'b0;
          state_nx = IDLE;
        end else if (hit) begin
          cur_nx = g;
          dd_nx = req_cmd[g*CWIDTH +: CWIDTH];
          state_nx = ISSUE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= IW'(NREQ - 1);
      cur <= '0;
      ov <= 1'b0;
      oid <= '0;
      master_en <= 1'b0;
      driver_data <= '0;
      driver_cfg <= 2'b00;
      req_ack <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      cur <= cur_nx;
      ov <= ov_nx;
      oid <= oid_nx;
      master_en <= men_nx;
      driver_data <= dd_nx;
      driver_cfg <= cfg_nx;
      req_ack <= ack_nx;
      rsp_valid <= rv_nx;
      rsp_data <= rd_nx;
      proto_err <= perr_nx;
    end
  end
endmodule

// File: tb/tb_spi_2_cmd_arbiter.sv
// tb_spi_2_cmd_arbiter: directed scenarios checked against a session-level model every cycle,
// plus hand-computed literal expectations at key points.
module tb_spi_2_cmd_arbiter;
  localparam int NREQ = 4, DW = 32, AW = 8, SW = 2, CW = SW + 3 + AW + DW;
  logic clk = 1'b0, rst_n = 1'b1, driver_read = 1'b0;
  logic [NREQ-1:0] req = '0, req_ack, rsp_valid;
  logic [NREQ*CW-1:0] req_cmd = '0;
  logic [DW-1:0] rsp_data, sdata = '0;
  logic [1:0] cfg_in = 2'b00, driver_cfg;
  logic master_en, proto_err;
  logic [CW-1:0] driver_data;
  int tests = 0, fails = 0;
  bit armed = 0;

  spi_2_cmd_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW), .S_ADDR_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cfg_in(cfg_in), .master_en(master_en),
    .driver_data(driver_data), .driver_cfg(driver_cfg), .driver_read(driver_read),
    .spi_slv_read_data(sdata), .proto_err(proto_err));

  always #5 clk = ~clk;

  // model: a session is open while busy; pend is the requester whose command awaits acceptance
  // (-1 while waiting for the closing pulse), oq holds ids still owed a response
  bit m_busy, m_gap;
  int m_pend, m_last;
  int m_oq[$];
  logic [NREQ-1:0] e_ack, e_rv;
  logic [DW-1:0] e_rd;
  logic e_men, e_perr;
  logic [CW-1:0] e_dd;
  logic [1:0] e_cfg;

  function automatic int pick(int last);
    for (int k = 1; k <= NREQ; k++)
      if (req[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_gap = 0; m_pend = -1; m_last = NREQ - 1; m_oq.delete();
      e_ack = '0; e_rv = '0; e_rd = '0; e_men = 0; e_perr = 0; e_dd = '0; e_cfg = 2'b00;
    end else begin
      e_ack = '0;
      e_rv = '0;
      if (!m_busy || m_gap) begin
        if (driver_read) e_perr = 1;
        if (!m_busy) e_cfg = cfg_in;
        m_pend = pick(m_last);
        if (m_pend >= 0) begin
          e_dd = req_cmd[m_pend*CW +: CW];
          m_busy = 1;
          e_men = 1;
        end
        m_gap = 0;
      end else if (driver_read) begin
        if (m_oq.size() > 0) begin
          e_rv[m_oq.pop_front()] = 1'b1;
          e_rd = sdata;
        end
        if (m_pend >= 0) begin
          e_ack[m_pend] = 1'b1;
          m_oq.push_back(m_pend);
          m_last = m_pend;
          m_pend = -1;
          m_gap = 1;
        end else begin
          m_busy = 0;
          e_men = 0;
        end
      end else if (m_pend < 0 && |req) begin
        m_pend = pick(m_last);
        e_dd = req_cmd[m_pend*CW +: CW];
      end
    end
  end

  always @(negedge clk) if (armed) begin
    tests++;
    if ({req_ack, rsp_valid, rsp_data, master_en, driver_data, driver_cfg, proto_err} !==
        {e_ack, e_rv, e_rd, e_men, e_dd, e_cfg, e_perr}) begin
      fails++;
      $display("FAIL model t=%0t: ack %b/%b rv %b/%b rd %h/%h men %b/%b dd %h/%h cfg %b/%b perr %b/%b (got/exp)",
               $time, req_ack, e_ack, rsp_valid, e_rv, rsp_data, e_rd, master_en, e_men,
               driver_data, e_dd, driver_cfg, e_cfg, proto_err, e_perr);
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(logic [1:0] ss, logic wr, logic [1:0] sz, logic [7:0] a, logic [31:0] d);
    return {ss, wr, sz, a, d};
  endfunction

  task automatic set_cmd(int i, logic [CW-1:0] c);
    req_cmd[i*CW +: CW] = c;
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(logic [DW-1:0] d);
    driver_read = 1'b1;
    sdata = d;
    tick();
    driver_read = 1'b0;
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int order[5] = '{0, 1, 2, 3, 0};
  logic [CW-1:0] c0, c1, cw, cr;

  initial begin
    #1 rst_n = 1'b0;
    tick();
    check("reset master_en", 64'(master_en), 64'd0);
    check("reset driver_data", 64'(driver_data), 64'd0);
    check("reset driver_cfg", 64'(driver_cfg), 64'd0);
    check("reset proto_err", 64'(proto_err), 64'd0);
    check("reset req_ack", 64'(req_ack), 64'd0);
    armed = 1;
    rst_n = 1'b1;
    tick();

    c0 = mk(2'b01, 1'b0, 2'b10, 8'h05, 32'h0);
    set_cmd(0, c0);
    req = 4'b0001;
    tick();
    check("single master_en", 64'(master_en), 64'd1);
    check("single driver_data", 64'(driver_data), 64'(c0));
    pulse(32'h1234_5678);
    req = '0;
    check("single ack", 64'(req_ack), 64'b0001);
    check("single no rsp", 64'(rsp_valid), 64'd0);
    tick(2);
    pulse(32'hA5A5_0001);
    check("single rsp_valid", 64'(rsp_valid), 64'b0001);
    check("single rsp_data", 64'(rsp_data), 64'hA5A5_0001);
    check("single master_en off", 64'(master_en), 64'd0);
    tick(2);

    do_reset();
    for (int i = 0; i < NREQ; i++) set_cmd(i, mk(2'(i), 1'b0, 2'b10, 8'h20 + 8'(i), 32'h0));
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      pulse(32'hB000_0000 + 32'(n));
      check("fair ack", 64'(req_ack), 64'(1) << order[n]);
      check("fair rsp", 64'(rsp_valid), n == 0 ? 64'd0 : 64'(1) << order[n-1]);
      set_cmd(order[n], mk(2'(order[n]), 1'b1, 2'b10, 8'h40 + 8'(n), 32'h1000 + 32'(n)));
      if (n == 4) req = '0;
      tick(2);
    end
    pulse(32'hB000_0005);
    check("fair last rsp", 64'(rsp_valid), 64'b0001);
    check("fair last data", 64'(rsp_data), 64'hB000_0005);
    check("fair close", 64'(master_en), 64'd0);
    tick(2);

    do_reset();
    cw = mk(2'b00, 1'b1, 2'b10, 8'h10, 32'hDEAD_BEEF);
    cr = mk(2'b00, 1'b0, 2'b10, 8'h10, 32'h0);
    set_cmd(2, cw);
    req = 4'b0100;
    tick();
    check("wr driver_data", 64'(driver_data), 64'(cw));
    pulse(32'h1111_1111);
    check("wr ack", 64'(req_ack), 64'b0100);
    set_cmd(2, cr);
    tick(2);
    check("rd driver_data", 64'(driver_data), 64'(cr));
    pulse(32'h2222_2222);
    check("rd ack", 64'(req_ack), 64'b0100);
    check("wr rsp", 64'(rsp_valid), 64'b0100);
    req = '0;
    tick(2);
    pulse(32'h3333_CAFE);
    check("rd rsp", 64'(rsp_valid), 64'b0100);
    check("rd data", 64'(rsp_data), 64'h3333_CAFE);
    check("wr/rd close", 64'(master_en), 64'd0);
    tick(2);

    do_reset();
    c1 = mk(2'b10, 1'b0, 2'b01, 8'h77, 32'h0);
    set_cmd(0, c0);
    req = 4'b0001;
    tick();
    pulse(32'h0);
    req = '0;
    tick(3);
    set_cmd(1, c1);
    req = 4'b0010;
    tick();
    check("rejoin master_en", 64'(master_en), 64'd1);
    check("rejoin driver_data", 64'(driver_data), 64'(c1));
    tick();
    pulse(32'hC0DE_0001);
    req = '0;
    check("rejoin ack", 64'(req_ack), 64'b0010);
    check("rejoin rsp", 64'(rsp_valid), 64'b0001);
    check("rejoin data", 64'(rsp_data), 64'hC0DE_0001);
    tick(2);
    pulse(32'hC0DE_0002);
    check("rejoin close rsp", 64'(rsp_valid), 64'b0010);
    check("rejoin close", 64'(master_en), 64'd0);
    tick(2);

    do_reset();
    cfg_in = 2'b11;
    tick();
    check("cfg idle", 64'(driver_cfg), 64'b11);
    set_cmd(0, c0);
    req = 4'b0001;
    tick();
    cfg_in = 2'b01;
    tick(2);
    check("cfg held issue", 64'(driver_cfg), 64'b11);
    pulse(32'h0);
    req = '0;
    tick(2);
    check("cfg held drain", 64'(driver_cfg), 64'b11);
    pulse(32'h0);
    check("cfg held close", 64'(driver_cfg), 64'b11);
    tick();
    check("cfg idle update", 64'(driver_cfg), 64'b01);

    pulse(32'hFFFF_FFFF);
    check("proto_err set", 64'(proto_err), 64'd1);
    check("proto no ack", 64'(req_ack), 64'd0);
    check("proto no session", 64'(master_en), 64'd0);
    tick(2);
    check("proto_err sticky", 64'(proto_err), 64'd1);

    set_cmd(0, c0);
    req = 4'b0001;
    tick();
    pulse(32'h0);
    set_cmd(0, c1);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("async master_en", 64'(master_en), 64'd0);
    check("async driver_data", 64'(driver_data), 64'd0);
    check("async proto_err", 64'(proto_err), 64'd0);
    check("async driver_cfg", 64'(driver_cfg), 64'd0);
    req = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post-reset no rsp", 64'(rsp_valid), 64'd0);
    end
    check("post-reset idle", 64'(master_en), 64'd0);

    armed = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
